// File: rtl/seq_rep_monitor.sv
// rtl/seq_rep_monitor.sv - checker for start |=> strong(x<op>n ##1 y) with timeout
module seq_rep_monitor #(
    parameter int CW      = 4,
    parameter int TW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] n,
    input  logic          x,
    input  logic          y,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [CW-1:0] hit_cnt,
    output logic          cfg_err,
    output logic          ovl
);

    typedef enum logic [1:0] {IDLE, COUNT, WAIT_Y} state_t;

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] hit_q, hit_d;
    logic [TW-1:0] cyc_q, cyc_d;
    logic          busy_q, busy_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic [1:0]    code_q, code_d;
    logic          cfg_pend_q, cfg_pend_d;
    logic          cfg_err_q, cfg_err_d;
    logic          ovl_pend_q, ovl_pend_d;
    logic          ovl_q, ovl_d;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        n_d        = n_q;
        hit_d      = hit_q;
        cyc_d      = cyc_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        code_d     = 2'd0;
        cfg_pend_d = 1'b0;
        ovl_pend_d = 1'b0;
        // Config errors and overlaps are reported one cycle after the start is sampled.
        cfg_err_d  = cfg_pend_q;
        ovl_d      = ovl_pend_q;

        case (state_q)
            IDLE: begin
                // busy_q still high here means pass/fail was just reported.
                if (start) begin
                    if (busy_q) begin
                        ovl_pend_d = 1'b1;
                    end else if (n == '0 || mode == 2'd3) begin
                        cfg_pend_d = 1'b1;
                    end else begin
                        mode_d  = mode;
                        n_d     = n;
                        hit_d   = '0;
                        cyc_d   = '0;
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                ovl_pend_d = start;
                cyc_d      = cyc_q + 1'b1;
                if (mode_q == 2'd0 && !x) begin
                    fail_d  = 1'b1;
                    code_d  = 2'd1;
                    state_d = IDLE;
                end else if (x) begin
                    hit_d = hit_q + 1'b1;
                    if (hit_d == n_q) begin
                        state_d = WAIT_Y;
                    end
                end
            end
            WAIT_Y: begin
                ovl_pend_d = start;
                cyc_d      = cyc_q + 1'b1;
                if (y) begin
                    pass_d  = 1'b1;
                    state_d = IDLE;
                end else if (mode_q != 2'd2 || x) begin
                    fail_d  = 1'b1;
                    code_d  = 2'd2;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An x/y verdict on the last allowed cycle wins over the timeout.
        if (state_q != IDLE && !pass_d && !fail_d && cyc_d == TW'(TIMEOUT)) begin
            fail_d  = 1'b1;
            code_d  = 2'd3;
            state_d = IDLE;
        end

        busy_d = (state_d != IDLE) || pass_d || fail_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 2'd0;
            n_q        <= '0;
            hit_q      <= '0;
            cyc_q      <= '0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            code_q     <= 2'd0;
            cfg_pend_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            ovl_pend_q <= 1'b0;
            ovl_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            n_q        <= n_d;
            hit_q      <= hit_d;
            cyc_q      <= cyc_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            code_q     <= code_d;
            cfg_pend_q <= cfg_pend_d;
            cfg_err_q  <= cfg_err_d;
            ovl_pend_q <= ovl_pend_d;
            ovl_q      <= ovl_d;
        end
    end

    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = code_q;
    assign hit_cnt   = hit_q;
    assign cfg_err   = cfg_err_q;
    assign ovl       = ovl_q;

endmodule

// File: tb/tb_seq_rep_monitor.sv
// tb/tb_seq_rep_monitor.sv - directed self-checking bench for seq_rep_monitor
module tb_seq_rep_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] n = 4'd0;
    logic       x = 1'b0;
    logic       y = 1'b0;
    logic       busy, pass, fail, cfg_err, ovl;
    logic [1:0] fail_code;
    logic [3:0] hit_cnt;

    int checks = 0;
    int errors = 0;

    seq_rep_monitor #(.CW(4), .TW(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .n(n),
        .x(x), .y(y), .busy(busy), .pass(pass), .fail(fail),
        .fail_code(fail_code), .hit_cnt(hit_cnt), .cfg_err(cfg_err), .ovl(ovl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle k of an attempt is the k-th rising edge after the edge that samples start.
    task automatic run(input logic [1:0] m, input logic [3:0] nn,
                       input logic [127:0] xv, input logic [127:0] yv, input int st_at,
                       output int pc, output int fc, output int code,
                       output int oc, output int bsy, output int both);
        start = 1'b0; x = 1'b0; y = 1'b0;
        tick();
        start = 1'b1; mode = m; n = nn;
        tick();
        start = 1'b0;
        pc = -1; fc = -1; code = 0; oc = -1; bsy = 0; both = 0;
        for (int k = 1; k <= 100; k++) begin
            x = xv[k];
            y = yv[k];
            start = (k == st_at);
            tick();
            if (ovl && oc < 0) oc = k;
            if (pass && fail) both = 1;
            if (pass || fail) begin
                if (pass) pc = k;
                if (fail) begin
                    fc = k;
                    code = int'(fail_code);
                end
                bsy = int'(busy);
                break;
            end
        end
        start = 1'b0; x = 1'b0; y = 1'b0;
    endtask

    int pc, fc, code, oc, bsy, both, seen;
    logic [127:0] one = 128'd1;

    initial begin
        tick();
        check("rst_busy", busy, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_hit", hit_cnt, 0);
        check("rst_cfg", cfg_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // consecutive, n=2: x at 1,2, y at 3
        run(2'd0, 4'd2, (one << 1) | (one << 2), one << 3, -1, pc, fc, code, oc, bsy, both);
        check("c_pass_cyc", pc, 3);
        check("c_no_fail", fc, -1);
        check("c_busy_at_pass", bsy, 1);
        check("c_hit", hit_cnt, 2);
        check("c_excl", both, 0);

        // consecutive broken run: x 1,0,1
        run(2'd0, 4'd2, (one << 1) | (one << 3), one << 4, -1, pc, fc, code, oc, bsy, both);
        check("cb_fail_cyc", fc, 2);
        check("cb_code", code, 1);
        check("cb_hit", hit_cnt, 1);

        // goto, same pattern
        run(2'd1, 4'd2, (one << 1) | (one << 3), one << 4, -1, pc, fc, code, oc, bsy, both);
        check("g_pass_cyc", pc, 4);

        // goto, y arrives late
        run(2'd1, 4'd2, (one << 1) | (one << 4), one << 6, -1, pc, fc, code, oc, bsy, both);
        check("g_late_fail", fc, 5);
        check("g_late_code", code, 2);

        // non-consecutive: y may come later
        run(2'd2, 4'd2, (one << 1) | (one << 4), one << 6, -1, pc, fc, code, oc, bsy, both);
        check("nc_pass_cyc", pc, 6);

        // non-consecutive with extra x at 5
        run(2'd2, 4'd2, (one << 1) | (one << 4) | (one << 5), one << 6, -1, pc, fc, code, oc, bsy, both);
        check("nc_extra_fail", fc, 5);
        check("nc_extra_code", code, 2);

        // non-consecutive, y never: timeout; overlapping start at 3
        run(2'd2, 4'd2, (one << 1) | (one << 4), 128'd0, 3, pc, fc, code, oc, bsy, both);
        check("to_fail_cyc", fc, 64);
        check("to_code", code, 3);
        check("to_no_pass", pc, -1);
        check("to_ovl_cyc", oc, 4);
        check("to_hit", hit_cnt, 2);
        tick();
        check("to_busy_after", busy, 0);
        check("to_code_clear", fail_code, 0);
        check("to_hit_hold", hit_cnt, 2);

        // reset in the middle of a goto attempt
        start = 1'b1; mode = 2'd1; n = 4'd2;
        tick();
        start = 1'b0; x = 1'b1;
        tick();
        x = 1'b0;
        tick();
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hit", hit_cnt, 0);
        check("arst_pf", int'(pass) + int'(fail), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        x = 1'b1; y = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (pass || fail || busy) seen++;
        end
        x = 1'b0; y = 1'b0;
        check("post_rst_quiet", seen, 0);
        run(2'd0, 4'd2, (one << 1) | (one << 2), one << 3, -1, pc, fc, code, oc, bsy, both);
        check("post_rst_pass", pc, 3);

        // illegal configurations
        tick();
        start = 1'b1; mode = 2'd0; n = 4'd0;
        tick();
        start = 1'b0;
        check("cfg0_busy", busy, 0);
        tick();
        check("cfg0_err", cfg_err, 1);
        check("cfg0_busy2", busy, 0);
        tick();
        check("cfg0_pulse", cfg_err, 0);
        start = 1'b1; mode = 2'd3; n = 4'd2;
        tick();
        start = 1'b0;
        tick();
        check("cfg3_err", cfg_err, 1);
        check("cfg3_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_rep_monitor.md
SEQ_REP_MONITOR -- requirements
Module: seq_rep_monitor

Interface
REQ-001 The block SHALL have parameter CW, default 4, meaning the width of the repetition count n.
REQ-002 The block SHALL have parameter TW, default 8, meaning the width of the timeout counter.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles an attempt may run; legal range is (2**CW)+1 < TIMEOUT < 2**TW.
REQ-004 clk  input  1  sole clock; all state is sampled on the posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  attempt trigger (antecedent).
REQ-007 mode  input  2  repetition kind: 0 = consecutive [*n], 1 = goto [->n], 2 = non-consecutive [=n], 3 = reserved.
REQ-008 n  input  CW  repetition count; sampled together with start.
REQ-009 x  input  1  repeated operand.
REQ-010 y  input  1  trailing operand (the "##1 y" term).
REQ-011 busy  output  1  an attempt is in progress.
REQ-012 pass  output  1  one-cycle pulse: the attempt matched.
REQ-013 fail  output  1  one-cycle pulse: the attempt did not match.
REQ-014 fail_code  output  2  valid while fail=1: 1 = x run broken, 2 = y missing or extra x, 3 = timeout.
REQ-015 hit_cnt  output  CW  number of x occurrences counted in the current attempt.
REQ-016 cfg_err  output  1  one-cycle pulse: start was sampled with n=0 or mode=3.
REQ-017 ovl  output  1  one-cycle pulse: start was sampled while busy=1.

Function
REQ-018 The block SHALL check "start |=> strong(x<op>n ##1 y)" as a synthesizable FSM with states IDLE, COUNT and WAIT_Y.
REQ-019 In IDLE, a sampled start with a legal n and mode SHALL latch mode and n, clear hit_cnt and the cycle counter, and enter COUNT; evaluation begins on the next cycle (cycle 1).
REQ-020 In IDLE, a sampled start with an illegal n or mode SHALL pulse cfg_err on the next cycle and SHALL remain in IDLE.
REQ-021 busy SHALL be 1 in COUNT and WAIT_Y, including the cycle in which pass or fail is asserted.
REQ-022 A start sampled while busy SHALL be ignored and SHALL pulse ovl on the next cycle; only one attempt is tracked at a time.
REQ-023 COUNT, mode 0, x=1: hit_cnt SHALL increment; when it reaches n the FSM SHALL go to WAIT_Y.
REQ-024 COUNT, mode 0, x=0: fail SHALL pulse with fail_code=1 and the FSM SHALL go to IDLE.
REQ-025 COUNT, modes 1 and 2: x=1 SHALL increment hit_cnt and x=0 SHALL hold it; on the nth hit the FSM SHALL go to WAIT_Y; y SHALL be ignored in COUNT.
REQ-026 WAIT_Y, modes 0 and 1: y=1 SHALL pulse pass, otherwise fail SHALL pulse with fail_code=2; in either case the FSM SHALL go to IDLE (single-cycle window).
REQ-027 WAIT_Y, mode 2: y=1 SHALL pulse pass regardless of x; else x=1 SHALL pulse fail with fail_code=2 (extra occurrence); else the FSM SHALL stay in WAIT_Y.
REQ-028 The cycle counter SHALL increment each busy cycle; if an attempt is still unresolved after evaluating cycle TIMEOUT, fail SHALL pulse that cycle with fail_code=3.
REQ-029 A pass or fail from x/y evaluation on cycle TIMEOUT SHALL take precedence over the timeout.
REQ-030 pass and fail SHALL be mutually exclusive; fail_code SHALL be 0 whenever fail=0.
REQ-031 hit_cnt SHALL saturate at n and SHALL hold its final value in IDLE until the next accepted start.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE and drive busy, pass, fail, fail_code, hit_cnt, cfg_err and ovl to 0.
REQ-034 A reset during an attempt SHALL abort it with no pass or fail pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-035 mode=0, n=2; start@c0; x=1@c1,c2, y=1@c3 -> pass@c3.
REQ-036 mode=0, n=2; x pattern 1,0,1 @c1..c3, y@c4 -> fail@c2, fail_code=1.
REQ-037 The same pattern with mode=1 -> pass@c4; mode=1 with x@c1, c4 and y@c6 only -> fail@c5, fail_code=2.
REQ-038 mode=2, n=2; x@c1, c4; y@c6 -> pass@c6; repeat with an extra x@c5 -> fail@c5, fail_code=2.
REQ-039 mode=2, n=2; x@c1, c4; y never -> fail@c64, fail_code=3; start@c3 -> ovl@c4 and the attempt is unaffected.
REQ-040 rst_n=0 at c2 of a mode-1 attempt -> all outputs 0 immediately, no pass or fail; n=0 with start -> cfg_err next cycle, busy stays 0.
